// File: rtl/uart_rx_if.sv
// uart_rx_if: peripheral bus bundle between the machine bus (master) and a
// register-mapped responder (slave).
//   addr     - register select
//   ren      - read strobe, one cycle per access
//   rdata    - read data, valid while rd_valid is high
//   rd_valid - read response strobe, one cycle after ren
//   wen      - write strobe
//   wdata    - write data
interface uart_rx_if;
  logic [2:0] addr;
  logic       ren;
  logic [7:0] rdata;
  logic       rd_valid;
  logic       wen;
  logic [7:0] wdata;

  modport master (output addr, ren, wen, wdata, input rdata, rd_valid);
  modport slave  (input addr, ren, wen, wdata, output rdata, rd_valid);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: memory-mapped 8N1 UART receiver with a small receive FIFO.
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - register bus (slave side): 0 DATA (R, pops), 1 STATUS (R),
//          2 CTRL (W: bit0 clear OVR, bit1 clear FERR, bit2 flush FIFO)
//   rx   - serial input, idle high, asynchronous to clk
//   irq  - high while the FIFO holds at least one byte
module uart_rx #(
  parameter int CLK_DIV = 104,
  parameter int DEPTH   = 4
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus,
  input  logic      rx,
  output logic      irq
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          sync1_q, rxs_q;
  logic          push, ferr_set;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovr_q, ferr_q, irq_q;
  logic          rd_valid_q;
  logic [7:0]    rdata_q, rd_mux;

  logic avail, full, pop, ctrl_wr, flush, do_push, ovr_set;
  logic unused_wdata;

  assign unused_wdata = ^bus.wdata[7:3];

  // Two-flop synchroniser; presets to the idle level so reset never looks
  // like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  // Receive FSM: START samples at mid start bit, so every later sample
  // taken CLK_DIV cycles apart lands mid-bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          if (rxs_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        // Hold here until the line returns high so a stuck-low line does
        // not produce a stream of bogus frames.
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // FIFO control: a pop frees the slot a same-cycle push needs, so a full
  // FIFO accepts the push without overrun; flush beats everything.
  assign avail   = (count_q != '0);
  assign full    = (count_q == FULL_CNT);
  assign pop     = bus.ren && (bus.addr == 3'd0) && avail;
  assign ctrl_wr = bus.wen && (bus.addr == 3'd2);
  assign flush   = ctrl_wr && bus.wdata[2];
  assign do_push = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (pop)     rptr_d = rptr_q + 1'b1;
      if (do_push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= shift_q;
  end

  // Sticky flags: a new error event outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovr_q   <= ovr_set  || (ovr_q  && !(ctrl_wr && bus.wdata[0]));
      ferr_q  <= ferr_set || (ferr_q && !(ctrl_wr && bus.wdata[1]));
      irq_q   <= (count_d != '0);
    end
  end

  // Registered read response; rdata is forced to zero outside the strobe.
  always_comb begin
    rd_mux = 8'h00;
    case (bus.addr)
      3'd0:    rd_mux = avail ? mem_q[rptr_q] : 8'h00;
      3'd1:    rd_mux = {4'b0000, ferr_q, ovr_q, full, avail};
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      rd_valid_q <= bus.ren;
      rdata_q    <= bus.ren ? rd_mux : 8'h00;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rd_valid = rd_valid_q;
  assign irq          = irq_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (CLK_DIV=8, DEPTH=4).
// A frame-level model (byte queue plus OVR/FERR flags) predicts every
// register read; directed scenarios are followed by a randomized mix.
module tb_uart_rx;
  localparam int CLK_DIV = 8;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic irq;

  uart_rx_if bus ();

  uart_rx #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .rx  (rx),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  logic       m_ovr;
  logic       m_ferr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {4'b0000, m_ferr, m_ovr, mq.size() == DEPTH, mq.size() != 0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serialise one frame; stop_low_bits > 0 holds the stop bit low that
  // many bit times (framing error), then the line idles high for 2 bits.
  task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
    rx = 1'b0;
    wait_cyc(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CLK_DIV);
    end
    if (stop_low_bits > 0) begin
      rx = 1'b0;
      wait_cyc(CLK_DIV * stop_low_bits);
    end
    rx = 1'b1;
    wait_cyc(CLK_DIV * 2);
    if (stop_low_bits > 0)      m_ferr = 1'b1;
    else if (mq.size() == DEPTH) m_ovr = 1'b1;
    else                         mq.push_back(b);
  endtask

  task automatic glitch(input int n);
    rx = 1'b0;
    wait_cyc(n);
    rx = 1'b1;
    wait_cyc(CLK_DIV * 2);
  endtask

  task automatic bus_read(input string tag, input logic [2:0] a, output logic [7:0] d);
    bus.addr = a;
    bus.ren  = 1'b1;
    @(negedge clk);
    bus.ren = 1'b0;
    check_val({tag, "_vld"}, {31'd0, bus.rd_valid}, 32'd1);
    d = bus.rdata;
    @(negedge clk);
    check_val({tag, "_vld_drop"}, {31'd0, bus.rd_valid}, 32'd0);
  endtask

  task automatic read_data_chk(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    if (mq.size() > 0) e = mq.pop_front();
    else               e = 8'h00;
    bus_read(tag, 3'd0, d);
    check_val(tag, {24'd0, d}, {24'd0, e});
    check_val({tag, "_irq"}, {31'd0, irq}, {31'd0, mq.size() != 0});
  endtask

  task automatic read_status_chk(input string tag);
    logic [7:0] d;
    bus_read(tag, 3'd1, d);
    check_val(tag, {24'd0, d}, {24'd0, m_status()});
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] w);
    bus.addr  = a;
    bus.wdata = w;
    bus.wen   = 1'b1;
    @(negedge clk);
    bus.wen = 1'b0;
    if (a == 3'd2) begin
      if (w[0]) m_ovr  = 1'b0;
      if (w[1]) m_ferr = 1'b0;
      if (w[2]) mq.delete();
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [2:0] a;
    rst = 1'b1;
    rx  = 1'b1;
    bus.addr  = 3'd0;
    bus.ren   = 1'b0;
    bus.wen   = 1'b0;
    bus.wdata = 8'h00;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    wait_cyc(3);
    check_val("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check_val("rst_rdata", {24'd0, bus.rdata}, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    wait_cyc(2);
    read_status_chk("rst_status");

    // Two clean frames
    send_frame(8'h55, 0);
    read_status_chk("status_after_55");
    check_val("irq_after_55", {31'd0, irq}, 32'd1);
    send_frame(8'hA3, 0);
    read_data_chk("data_55");
    read_data_chk("data_a3");
    read_status_chk("status_drained");

    // Short low pulse must be rejected as a false start
    glitch(3);
    read_status_chk("status_glitch");

    // Framing error, break, then recovery
    send_frame(8'h7E, 20);
    read_status_chk("status_ferr");
    send_frame(8'h11, 0);
    read_status_chk("status_ferr_avail");
    bus_write(3'd2, 8'h02);
    read_status_chk("status_ferr_clr");
    read_data_chk("data_11");

    // Overrun
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0);
    read_status_chk("status_ovr");
    for (int i = 0; i < 5; i++) read_data_chk("data_ovr_drain");
    bus_write(3'd2, 8'h01);
    read_status_chk("status_ovr_clr");

    // Empty DATA reads, back-to-back
    bus.addr = 3'd0;
    bus.ren  = 1'b1;
    @(negedge clk);
    check_val("b2b_vld1", {31'd0, bus.rd_valid}, 32'd1);
    check_val("b2b_data1", {24'd0, bus.rdata}, 32'd0);
    @(negedge clk);
    bus.ren = 1'b0;
    check_val("b2b_vld2", {31'd0, bus.rd_valid}, 32'd1);
    check_val("b2b_data2", {24'd0, bus.rdata}, 32'd0);
    @(negedge clk);
    check_val("b2b_vld_drop", {31'd0, bus.rd_valid}, 32'd0);
    read_status_chk("status_empty_reads");

    // Reset in the middle of a frame, released while the line is low
    send_frame(8'h33, 0);
    rx = 1'b0;
    wait_cyc(CLK_DIV);
    rx = 1'b1;
    wait_cyc(CLK_DIV * 3);
    rx = 1'b0;
    wait_cyc(4);
    bus.addr = 3'd1;
    bus.ren  = 1'b1;
    @(posedge clk);
    #1;
    bus.ren = 1'b0;
    check_val("pre_rst_vld", {31'd0, bus.rd_valid}, 32'd1);
    check_val("pre_rst_status", {24'd0, bus.rdata}, 32'h01);
    check_val("pre_rst_irq", {31'd0, irq}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_val("async_rst_vld", {31'd0, bus.rd_valid}, 32'd0);
    check_val("async_rst_rdata", {24'd0, bus.rdata}, 32'd0);
    check_val("async_rst_irq", {31'd0, irq}, 32'd0);
    wait_cyc(2);
    rst = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    wait_cyc(CLK_DIV * 12);
    rx = 1'b1;
    wait_cyc(CLK_DIV * 2);
    m_ferr = 1'b1;
    read_status_chk("status_post_rst");
    bus_write(3'd2, 8'h02);
    read_status_chk("status_post_rst_clr");
    send_frame(8'h42, 0);
    read_data_chk("data_42");

    // Randomized mix of traffic and register accesses
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 8))
        0, 1: send_frame(8'($urandom), 0);
        2:    send_frame(8'($urandom), int'($urandom_range(1, 3)));
        3:    read_data_chk("rnd_data");
        4:    read_status_chk("rnd_status");
        5:    bus_write(3'd2, 8'($urandom_range(0, 7)));
        6:    glitch(int'($urandom_range(1, 3)));
        7: begin
          a = 3'($urandom_range(2, 7));
          bus_read("rnd_unmapped", a, d);
          check_val("rnd_unmapped", {24'd0, d}, 32'd0);
        end
        default: begin
          a = 3'($urandom_range(0, 6));
          if (a >= 3'd2) a = a + 3'd1;
          bus_write(a, 8'($urandom));
        end
      endcase
    end
    read_status_chk("final_status");
    while (mq.size() > 0) read_data_chk("final_drain");
    read_status_chk("final_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
